booth_multiplier_param: RTL and testbench

Parametrised sequential radix-4 Booth multiplier. It is the next-generation replacement for the radix-2 64x64 multiplier used by the factorial computation system. It generalises the operand width, adds a per-operation signed/unsigned mode and a busy flag, and halves the iteration count. It keeps the op_start / op_clear / op_done handshake, so the factorial controller can drive it unchanged.

---
 rtl/booth_multiplier_param.sv | 162 ++++++++++++++++
 tb/tb_booth_multiplier_param.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/booth_multiplier_param.sv
`default_nettype none
// ============================================================================
// Module   : booth_multiplier_param
// Brief    : Sequential radix-4 Booth multiplier, WIDTH x WIDTH -> 2*WIDTH,
//            per-operation signed/unsigned mode, op_start/op_clear/op_done.
// Revision : 1.0 - initial release
// ============================================================================
module booth_multiplier_param #(
    parameter int WIDTH     = 64,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               op_start_i,
    input  logic               op_clear_i,
    input  logic               signed_mode_i,
    input  logic [WIDTH-1:0]   multiplier_i,
    input  logic [WIDTH-1:0]   multiplicand_i,
    output logic               op_busy_o,
    output logic               op_done_o,
    output logic [2*WIDTH-1:0] result_o
);

    localparam int EXT_W = WIDTH + 2;
    localparam int ACC_W = EXT_W + 2;
    localparam int N_ITER = EXT_W / 2;
    localparam int CNT_W = $clog2(N_ITER + 1);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(N_ITER);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic [EXT_W:0]       mul_q, mul_d;
    logic [EXT_W-1:0]     mcand_q, mcand_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [2*WIDTH-1:0]   result_q, result_d;

    logic                 w_signed;
    logic [EXT_W-1:0]     w_a_ext;
    logic [EXT_W-1:0]     w_b_ext;
    logic [ACC_W-1:0]     w_b_sx;
    logic [ACC_W-1:0]     w_addend;
    logic [ACC_W-1:0]     w_sum;
    logic [ACC_W-1:0]     w_acc_sh;
    logic [EXT_W:0]       w_mul_sh;

    generate
        if (SIGNED_EN) begin : g_signed_en
            assign w_signed = signed_mode_i;
        end else begin : g_unsigned_only
            assign w_signed = 1'b0;
        end
    endgenerate

    // Two extra bits keep unsigned operands positive under signed Booth recoding
    assign w_a_ext = w_signed ? {{2{multiplier_i[WIDTH-1]}}, multiplier_i}
                              : {2'b00, multiplier_i};
    assign w_b_ext = w_signed ? {{2{multiplicand_i[WIDTH-1]}}, multiplicand_i}
                              : {2'b00, multiplicand_i};

    assign w_b_sx = {{2{mcand_q[EXT_W-1]}}, mcand_q};

    always_comb begin
        w_addend = '0;
        case (mul_q[2:0])
            3'b001, 3'b010: w_addend = w_b_sx;
            3'b011:         w_addend = w_b_sx << 1;
            3'b100:         w_addend = -(w_b_sx << 1);
            3'b101, 3'b110: w_addend = -w_b_sx;
            default:        w_addend = '0;
        endcase
    end

    assign w_sum    = acc_q + w_addend;
    assign w_acc_sh = {{2{w_sum[ACC_W-1]}}, w_sum[ACC_W-1:2]};
    assign w_mul_sh = {w_sum[1:0], mul_q[EXT_W:2]};

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mul_d    = mul_q;
        mcand_d  = mcand_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = done_q;
        result_d = result_q;
        if (op_clear_i) begin
            state_d  = S_IDLE;
            busy_d   = 1'b0;
            done_d   = 1'b0;
            result_d = '0;
            cnt_d    = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (op_start_i) begin
                        acc_d   = '0;
                        mul_d   = {w_a_ext, 1'b0};
                        mcand_d = w_b_ext;
                        cnt_d   = '0;
                        busy_d  = 1'b1;
                        state_d = S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (cnt_q == C_LAST) begin
                        // Multiplier bits are fully shifted out; product low half sits in mul_q
                        result_d = {acc_q[WIDTH-3:0], mul_q[EXT_W:1]};
                        done_d   = 1'b1;
                        busy_d   = 1'b0;
                        state_d  = S_DONE;
                    end else begin
                        acc_d = w_acc_sh;
                        mul_d = w_mul_sh;
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    state_d = S_DONE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            mul_q    <= '0;
            mcand_q  <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mul_q    <= mul_d;
            mcand_q  <= mcand_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    assign op_busy_o = busy_q;
    assign op_done_o = done_q;
    assign result_o  = result_q;

endmodule
`default_nettype wire

// File: tb/tb_booth_multiplier_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_booth_multiplier_param
// Brief    : Randomised bench for 64-bit and 8-bit Booth multiplier instances
//            against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_booth_multiplier_param;

    logic         clk = 1'b0;
    logic         reset = 1'b1;

    logic         start64 = 1'b0, clear64 = 1'b0, smode64 = 1'b0;
    logic [63:0]  a64 = '0, b64 = '0;
    logic         busy64, done64;
    logic [127:0] res64;

    logic         start8 = 1'b0, clear8 = 1'b0, smode8 = 1'b0;
    logic [7:0]   a8 = '0, b8 = '0;
    logic         busy8, done8;
    logic [15:0]  res8;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    booth_multiplier_param #(.WIDTH(64), .SIGNED_EN(1'b1)) u_dut64 (
        .clk_i(clk), .reset_i(reset), .op_start_i(start64), .op_clear_i(clear64),
        .signed_mode_i(smode64), .multiplier_i(a64), .multiplicand_i(b64),
        .op_busy_o(busy64), .op_done_o(done64), .result_o(res64)
    );

    booth_multiplier_param #(.WIDTH(8), .SIGNED_EN(1'b1)) u_dut8 (
        .clk_i(clk), .reset_i(reset), .op_start_i(start8), .op_clear_i(clear8),
        .signed_mode_i(smode8), .multiplier_i(a8), .multiplicand_i(b8),
        .op_busy_o(busy8), .op_done_o(done8), .result_o(res8)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Exact product of w-bit operands, truncated to 2w bits
    function automatic logic [127:0] ref_mul(input logic [63:0] a, input logic [63:0] b,
                                             input logic s, input int w);
        logic [127:0] m, xa, xb;
        m  = (128'd1 << w) - 128'd1;
        xa = {64'd0, a} & m;
        xb = {64'd0, b} & m;
        if (s && xa[w-1]) xa = xa | ~m;
        if (s && xb[w-1]) xb = xb | ~m;
        return (xa * xb) & ((128'd1 << (2 * w)) - 128'd1);
    endfunction

    task automatic run64(input logic [63:0] a, input logic [63:0] b, input logic s,
                         input string tag);
        logic [127:0] exp;
        int n;
        exp = ref_mul(a, b, s, 64);
        @(negedge clk);
        a64 = a; b64 = b; smode64 = s; start64 = 1'b1;
        @(negedge clk);
        start64 = 1'b0;
        a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom}; smode64 = ~s;
        check({tag, ":busy"}, {127'd0, busy64}, 128'd1);
        n = 0;
        while (!done64 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, ":lat"}, 128'(n), 128'd34);
        check({tag, ":res"}, res64, exp);
        check({tag, ":busy_at_done"}, {127'd0, busy64}, 128'd0);
        @(negedge clk);
        clear64 = 1'b1;
        @(negedge clk);
        clear64 = 1'b0;
        check({tag, ":clr_res"}, res64, 128'd0);
        check({tag, ":clr_done"}, {127'd0, done64}, 128'd0);
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic s,
                        input string tag);
        logic [127:0] exp;
        int n;
        exp = ref_mul({56'd0, a}, {56'd0, b}, s, 8);
        @(negedge clk);
        a8 = a; b8 = b; smode8 = s; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); smode8 = ~s;
        n = 0;
        while (!done8 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, ":lat"}, 128'(n), 128'd6);
        check({tag, ":res"}, {112'd0, res8}, exp);
        @(negedge clk);
        clear8 = 1'b1;
        @(negedge clk);
        clear8 = 1'b0;
        check({tag, ":clr_res"}, {112'd0, res8}, 128'd0);
    endtask

    initial begin
        logic seen;
        int n;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_res64", res64, 128'd0);
        check("rst_busy64", {127'd0, busy64}, 128'd0);
        check("rst_done64", {127'd0, done64}, 128'd0);
        check("rst_res8", {112'd0, res8}, 128'd0);

        run64({64{1'b1}}, {64{1'b1}}, 1'b0, "u_max");
        check("u_max_const", ref_mul({64{1'b1}}, {64{1'b1}}, 1'b0, 64),
              {64'hFFFF_FFFF_FFFF_FFFE, 64'h0000_0000_0000_0001});
        run64({64{1'b1}}, {64{1'b1}}, 1'b1, "s_m1m1");
        run64(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, "s_minmin");
        run64(64'd5, -64'sd3, 1'b1, "s_5xm3");
        run64(64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, "s_minmax");
        for (int i = 0; i < 20; i++)
            run64({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), "rnd64");

        run8(8'h80, 8'h7F, 1'b1, "s8_80x7f");
        run8(8'h80, 8'h7F, 1'b0, "u8_80x7f");
        run8(8'h80, 8'h80, 1'b1, "s8_minmin");
        for (int i = 0; i < 16; i++)
            run8(8'($urandom), 8'($urandom), 1'($urandom), "rnd8");

        // Handshake: mid-BUSY and DONE starts are ignored
        @(negedge clk);
        a64 = 64'd12; b64 = 64'd13; smode64 = 1'b0; start64 = 1'b1;
        @(negedge clk);
        start64 = 1'b0;
        repeat (5) @(negedge clk);
        a64 = 64'd99; b64 = 64'd77; start64 = 1'b1;
        @(negedge clk);
        start64 = 1'b0;
        n = 0;
        while (!done64 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("hs_res", res64, 128'd156);
        a64 = 64'd3; b64 = 64'd3; start64 = 1'b1;
        @(negedge clk);
        start64 = 1'b0;
        repeat (3) @(negedge clk);
        check("hs_done_hold_res", res64, 128'd156);
        check("hs_done_hold_done", {127'd0, done64}, 128'd1);
        check("hs_done_hold_busy", {127'd0, busy64}, 128'd0);
        clear64 = 1'b1;
        @(negedge clk);
        clear64 = 1'b0;
        check("hs_clr_res", res64, 128'd0);
        check("hs_clr_done", {127'd0, done64}, 128'd0);
        run64(64'd7, 64'd9, 1'b0, "hs_next");

        // Abort mid-BUSY
        @(negedge clk);
        a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom}; start64 = 1'b1;
        @(negedge clk);
        start64 = 1'b0;
        repeat (9) @(negedge clk);
        check("abort_busy_before", {127'd0, busy64}, 128'd1);
        clear64 = 1'b1;
        @(negedge clk);
        clear64 = 1'b0;
        check("abort_busy", {127'd0, busy64}, 128'd0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            seen = seen | done64 | busy64;
        end
        check("abort_no_done", {127'd0, seen}, 128'd0);

        // Clear and start together from IDLE
        clear64 = 1'b1; start64 = 1'b1;
        @(negedge clk);
        clear64 = 1'b0; start64 = 1'b0;
        check("clrstart_busy", {127'd0, busy64}, 128'd0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            seen = seen | done64 | busy64;
        end
        check("clrstart_idle", {127'd0, seen}, 128'd0);

        // Asynchronous reset mid-BUSY
        @(negedge clk);
        a64 = {64{1'b1}}; b64 = {64{1'b1}}; smode64 = 1'b0; start64 = 1'b1;
        @(negedge clk);
        start64 = 1'b0;
        repeat (5) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("arst_busy", {127'd0, busy64}, 128'd0);
        check("arst_done", {127'd0, done64}, 128'd0);
        check("arst_res", res64, 128'd0);
        @(negedge clk);
        reset = 1'b0;
        run64(64'd0, {64{1'b1}}, 1'b0, "post_rst_zero");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
